mem_responder: RTL and testbench

Synthesizable main-memory responder at the far end of the cache-to-memory block interface. Accepts one block read or write at a time from the last-level cache (L1, or L2 when built with L2), holds it for a fixed latency, then completes with a one-cycle ready pulse and, for reads, the addressed block. Used as the memory side of chip-level simulation and as the reference responder for cache verification.

---
 rtl/mem_responder_pkg.sv | 24 ++
 rtl/mem_responder_ram.sv | 34 +++
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and address-split helpers for the block-memory responder.
// Index/offset widths are derived from block width and storage depth.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  function automatic int calc_ofs(input int bw_block);
    return $clog2(bw_block / 8);
  endfunction

  function automatic int calc_idx(input int num_block);
    return $clog2(num_block);
  endfunction

  localparam int DEF_BW_BLOCK  = 128;
  localparam int DEF_NUM_BLOCK = 1024;
  localparam int OFS = calc_ofs(DEF_BW_BLOCK);
  localparam int IDX = calc_idx(DEF_NUM_BLOCK);

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous block RAM with registered read data.
// Neither the array nor the read register is reset.
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency main-memory responder: one block read/write in flight,
// one-cycle ready pulse on completion, sticky protocol-violation flag.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int BW_ADDRESS = 32,
  parameter int BW_BLOCK   = 128,
  parameter int NUM_BLOCK  = 1024,
  parameter int LATENCY    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_r0w1,
  input  logic [BW_ADDRESS-1:0] mem_rwaddr,
  input  logic [BW_BLOCK-1:0]   mem_wdata,
  output logic                  mem_ready,
  output logic [BW_BLOCK-1:0]   mem_rdata,
  output logic                  mem_err
);

  localparam int OFS_B = calc_ofs(BW_BLOCK);
  localparam int IDX_B = calc_idx(NUM_BLOCK);
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  rvld_q, rvld_d;
  logic                  r0w1_q, r0w1_d;
  logic [BW_ADDRESS-1:0] addr_q, addr_d;
  logic [BW_BLOCK-1:0]   wdata_q, wdata_d;

  logic                  ram_en;
  logic                  ram_we;
  logic [IDX_B-1:0]      ram_addr;
  logic [BW_BLOCK-1:0]   ram_wdata;
  logic [BW_BLOCK-1:0]   ram_rdata;

  logic [IDX_B-1:0]      in_idx;
  logic [IDX_B-1:0]      idx_q;
  logic                  req_changed;

  assign in_idx = mem_rwaddr[OFS_B +: IDX_B];
  assign idx_q  = addr_q[OFS_B +: IDX_B];

  // Full address is compared so offset/alias bits count as a protocol change too.
  assign req_changed = !mem_valid || (mem_r0w1 != r0w1_q) ||
                       (mem_rwaddr != addr_q) || (mem_wdata != wdata_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rvld_d    = rvld_q;
    r0w1_d    = r0w1_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = idx_q;
    ram_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          r0w1_d  = mem_r0w1;
          addr_d  = mem_rwaddr;
          wdata_d = mem_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            // No WAIT phase: access the array straight from the live request.
            state_d   = RESP;
            ram_en    = 1'b1;
            ram_we    = mem_r0w1;
            ram_addr  = in_idx;
            ram_wdata = mem_wdata;
            if (!mem_r0w1) rvld_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (req_changed) err_d = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          ram_en  = 1'b1;
          ram_we  = r0w1_q;
          if (!r0w1_q) rvld_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rvld_q  <= rvld_d;
    end
  end

  always_ff @(posedge clk) begin
    r0w1_q  <= r0w1_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Reset must block an array write even while the request is still presented.
  mem_responder_ram #(
    .WIDTH (BW_BLOCK),
    .AW    (IDX_B)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en && !rst),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign mem_ready = (state_q == RESP);
  assign mem_rdata = rvld_q ? ram_rdata : '0;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: LATENCY=5 instance for most scenarios,
// LATENCY=1 instance for back-to-back throughput.
module tb_mem_responder;

  typedef logic [127:0] blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        valid = 1'b0, r0w1 = 1'b0;
  logic [31:0] addr  = '0;
  blk_t        wdata = '0;
  logic        ready, err;
  blk_t        rdata;

  logic        valid1 = 1'b0, r0w11 = 1'b0;
  logic [31:0] addr1  = '0;
  blk_t        wdata1 = '0;
  logic        ready1, err1;
  blk_t        rdata1;

  int n_checks = 0;
  int n_fail   = 0;

  blk_t model [int];
  blk_t last_rd;

  mem_responder #(.BW_ADDRESS(32), .BW_BLOCK(128), .NUM_BLOCK(1024), .LATENCY(5)) dut (
    .clk(clk), .rst(rst), .mem_valid(valid), .mem_r0w1(r0w1), .mem_rwaddr(addr),
    .mem_wdata(wdata), .mem_ready(ready), .mem_rdata(rdata), .mem_err(err)
  );

  mem_responder #(.BW_ADDRESS(32), .BW_BLOCK(128), .NUM_BLOCK(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_valid(valid1), .mem_r0w1(r0w11), .mem_rwaddr(addr1),
    .mem_wdata(wdata1), .mem_ready(ready1), .mem_rdata(rdata1), .mem_err(err1)
  );

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd16) % 32'd1024);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request from an IDLE cycle, returns edges-to-ready, data seen with
  // ready and ready level in the following cycle; leaves the DUT in IDLE.
  task automatic drive_txn(input logic w, input logic [31:0] a, input blk_t d,
                           output int lat, output blk_t rd, output logic rdy_after);
    valid = 1'b1; r0w1 = w; addr = a; wdata = d;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (ready === 1'b1) begin
        lat = c;
        break;
      end
    end
    rd = rdata;
    valid = 1'b0;
    step();
    rdy_after = ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({ready, err, rdata} !== {1'b0, 1'b0, 128'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b err=%b rdata=%h, required 0 0 0", ready, err, rdata);
    end
    n_checks++;
    if ({ready1, err1, rdata1} !== {1'b0, 1'b0, 128'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs_lat1: ready=%b err=%b rdata=%h, required 0 0 0", ready1, err1, rdata1);
    end
    rst = 1'b0;
    last_rd = '0;
    step();
  endtask

  task automatic test_basic();
    int lat; blk_t rd; logic ra;
    blk_t d = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    drive_txn(1'b1, 32'h40, d, lat, rd, ra);
    model[idx_of(32'h40)] = d;
    n_checks++;
    if (lat !== 5 || ra !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_write_timing: latency=%0d ready_after=%b, required 5 and 0", lat, ra);
    end
    n_checks++;
    if (rd !== last_rd) begin
      n_fail++;
      $display("FAIL basic_write_rdata_held: got %h, required %h", rd, last_rd);
    end
    drive_txn(1'b0, 32'h40, '0, lat, rd, ra);
    n_checks++;
    if (lat !== 5 || ra !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_read_timing: latency=%0d ready_after=%b, required 5 and 0", lat, ra);
    end
    n_checks++;
    if (rd !== d) begin
      n_fail++;
      $display("FAIL basic_read_data: got %h, required %h", rd, d);
    end
    last_rd = d;
  endtask

  task automatic test_alias();
    int lat; blk_t rd; logic ra;
    drive_txn(1'b1, 32'h40, 128'hA5, lat, rd, ra);
    model[idx_of(32'h40)] = 128'hA5;
    drive_txn(1'b0, 32'h4_0040, '0, lat, rd, ra);
    n_checks++;
    if (rd !== 128'hA5 || lat !== 5) begin
      n_fail++;
      $display("FAIL alias_high_bits: data %h latency %0d, required a5 and 5", rd, lat);
    end
    drive_txn(1'b0, 32'h4F, '0, lat, rd, ra);
    n_checks++;
    if (rd !== 128'hA5 || lat !== 5) begin
      n_fail++;
      $display("FAIL alias_offset_bits: data %h latency %0d, required a5 and 5", rd, lat);
    end
    last_rd = 128'hA5;
  endtask

  task automatic test_random();
    int lat; blk_t rd; logic ra;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic        w;
      blk_t        d;
      int          ix;
      a = {$urandom_range(3, 0) * 32'h4000, 16'h0} | (32'($urandom_range(7, 0)) << 4)
          | 32'($urandom_range(15, 0));
      ix = idx_of(a);
      w = ($urandom_range(1, 0) == 1) || !model.exists(ix);
      d = {$urandom, $urandom, $urandom, $urandom};
      drive_txn(w, a, w ? d : 128'h0, lat, rd, ra);
      n_checks++;
      if (lat !== 5 || ra !== 1'b0 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL random_timing[%0d]: latency=%0d ready_after=%b err=%b, required 5 0 0", i, lat, ra, err);
      end
      n_checks++;
      if (w) begin
        if (rd !== last_rd) begin
          n_fail++;
          $display("FAIL random_write_rdata_held[%0d]: got %h, required %h", i, rd, last_rd);
        end
        model[ix] = d;
      end else begin
        if (rd !== model[ix]) begin
          n_fail++;
          $display("FAIL random_read[%0d] addr %h: got %h, required %h", i, a, rd, model[ix]);
        end
        last_rd = model[ix];
      end
    end
  endtask

  task automatic test_hold_valid();
    int lat; blk_t rd; logic ra;
    blk_t a_d = 128'hAAAA_0000_1111_2222_3333_4444_5555_0040;
    blk_t b_d = 128'hBBBB_9999_8888_7777_6666_5555_4444_0080;
    logic [12:1] obs;
    drive_txn(1'b1, 32'h40, a_d, lat, rd, ra);
    drive_txn(1'b1, 32'h80, b_d, lat, rd, ra);
    model[idx_of(32'h40)] = a_d;
    model[idx_of(32'h80)] = b_d;
    valid = 1'b1; r0w1 = 1'b0; addr = 32'h40; wdata = '0;
    obs = '0;
    for (int c = 1; c <= 12; c++) begin
      step();
      obs[c] = ready;
      if (c == 5) begin
        n_checks++;
        if (rdata !== a_d) begin
          n_fail++;
          $display("FAIL hold_valid_first_data: got %h, required %h", rdata, a_d);
        end
        addr = 32'h80;
      end
      if (c == 11) begin
        n_checks++;
        if (rdata !== b_d) begin
          n_fail++;
          $display("FAIL hold_valid_second_data: got %h, required %h", rdata, b_d);
        end
        valid = 1'b0;
      end
    end
    n_checks++;
    if (obs !== 12'b0100_0001_0000) begin
      n_fail++;
      $display("FAIL hold_valid_ready_pattern: got %b, required %b", obs, 12'b0100_0001_0000);
    end
    last_rd = b_d;
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs;
    blk_t rd;
    valid1 = 1'b1; r0w11 = 1'b1; addr1 = 32'h20; wdata1 = 128'h11;
    step();
    obs[0] = ready1;
    r0w11 = 1'b0; wdata1 = '0;
    step();
    obs[1] = ready1;
    step();
    obs[2] = ready1;
    rd = rdata1;
    valid1 = 1'b0;
    step();
    obs[3] = ready1;
    n_checks++;
    if (obs !== 4'b0101) begin
      n_fail++;
      $display("FAIL back_to_back_ready: got %b (cycle0 at lsb), required 0101", obs);
    end
    n_checks++;
    if (rd !== 128'h11) begin
      n_fail++;
      $display("FAIL back_to_back_data: got %h, required 11", rd);
    end
  endtask

  task automatic test_protocol_err();
    int lat; blk_t rd; logic ra;
    blk_t e = 128'hE0E0_1234_5678_9ABC_DEF0_0F0F_F0F0_00E0;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear_before: got %b, required 0", err);
    end
    valid = 1'b1; r0w1 = 1'b1; addr = 32'h40; wdata = e;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 2) addr = 32'h80;
      if (ready === 1'b1) begin
        lat = c;
        break;
      end
    end
    valid = 1'b0;
    step();
    model[idx_of(32'h40)] = e;
    n_checks++;
    if (lat !== 5 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: latency=%0d err=%b, required 5 and 1", lat, err);
    end
    drive_txn(1'b0, 32'h40, '0, lat, rd, ra);
    n_checks++;
    if (rd !== e) begin
      n_fail++;
      $display("FAIL err_write_landed: got %h, required %h", rd, e);
    end
    drive_txn(1'b0, 32'h80, '0, lat, rd, ra);
    n_checks++;
    if (rd !== model[idx_of(32'h80)]) begin
      n_fail++;
      $display("FAIL err_other_index_untouched: got %h, required %h", rd, model[idx_of(32'h80)]);
    end
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
  endtask

  task automatic test_reset_mid();
    int lat; blk_t rd; logic ra;
    logic seen;
    drive_txn(1'b1, 32'h100, 128'hEE, lat, rd, ra);
    valid = 1'b1; r0w1 = 1'b1; addr = 32'h100; wdata = 128'hFF;
    step();
    step();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ready, err, rdata} !== {1'b0, 1'b0, 128'h0}) begin
      n_fail++;
      $display("FAIL midreset_outputs: ready=%b err=%b rdata=%h, required 0 0 0", ready, err, rdata);
    end
    valid = 1'b0;
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ready !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_ready: ready pulse seen=%b, required 0", seen);
    end
    drive_txn(1'b0, 32'h100, '0, lat, rd, ra);
    n_checks++;
    if (rd !== 128'hEE || lat !== 5) begin
      n_fail++;
      $display("FAIL midreset_write_aborted: data %h latency %0d, required ee and 5", rd, lat);
    end
    drive_txn(1'b1, 32'h100, 128'h22, lat, rd, ra);
    n_checks++;
    if (rd !== 128'hEE) begin
      n_fail++;
      $display("FAIL midreset_rdata_held: got %h, required ee", rd);
    end
    drive_txn(1'b0, 32'h100, '0, lat, rd, ra);
    n_checks++;
    if (rd !== 128'h22) begin
      n_fail++;
      $display("FAIL midreset_rewrite: got %h, required 22", rd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alias();
    test_random();
    test_hold_valid();
    test_back_to_back();
    test_protocol_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
